mem_burst_requester: RTL and testbench

Initiator side of the 32 x 8-bit data memory port. It accepts single- or multi-byte load/store requests from the multicycle control path and drives the memory's `memRead`, `memWrite`, `address` and `writeData` inputs one byte per cycle. It reassembles read bytes from the memory's registered `out` into a 32-bit response and returns one response pulse per request. It sits between the control unit/datapath and the `memory` instance.

---
 rtl/mem_req_pkg.sv | 18 +
 rtl/mem_rsp_packer.sv | 46 ++++
 rtl/mem_burst_requester.sv | 167 ++++++++++++++++
 tb/tb_mem_burst_requester.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the byte-wide data memory burst requester.
// Build option MEM_REQ_BURST_EN enables 1..4 beat bursts (single beat otherwise).
package mem_req_pkg;

    localparam int ADDR_W    = 5;
    localparam int BYTE_W    = 8;
    localparam int LEN_W     = 2;
    localparam int MAX_BEATS = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/mem_rsp_packer.sv
// Packs bytes returned by the memory into lanes of the 32-bit load response.
// With MEM_REQ_BURST_EN undefined only lane 0 is built.
module mem_rsp_packer
    import mem_req_pkg::*;
#(
    parameter int BYTE_W = mem_req_pkg::BYTE_W,
    parameter int LEN_W  = mem_req_pkg::LEN_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          beat_valid_i,
    input  logic [LEN_W-1:0]              lane_i,
    input  logic [BYTE_W-1:0]             byte_i,
    output logic [MAX_BEATS*BYTE_W-1:0]   data_o
);

`ifdef MEM_REQ_BURST_EN
    logic [MAX_BEATS*BYTE_W-1:0] pack_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            pack_q <= '0;
        end else if (beat_valid_i) begin
            pack_q[lane_i*BYTE_W +: BYTE_W] <= byte_i;
        end
    end

    assign data_o = pack_q;
`else
    logic [BYTE_W-1:0] lane0_q;
    logic              unused_lane;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            lane0_q <= '0;
        end else if (beat_valid_i) begin
            lane0_q <= byte_i;
        end
    end

    assign data_o      = {{((MAX_BEATS-1)*BYTE_W){1'b0}}, lane0_q};
    assign unused_lane = ^lane_i;
`endif

endmodule

// File: rtl/mem_burst_requester.sv
// Byte-per-cycle load/store initiator for the 32 x 8-bit data memory.
// Build option MEM_REQ_BURST_EN enables 1..4 beat bursts (single beat otherwise).
module mem_burst_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = mem_req_pkg::ADDR_W,
    parameter int BYTE_W = mem_req_pkg::BYTE_W,
    parameter int LEN_W  = mem_req_pkg::LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [4*BYTE_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [4*BYTE_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BYTE_W-1:0]     mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [BYTE_W-1:0]     mem_out
);

    state_t                state_q, state_d;
    logic                  write_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  bv_q, bv_d;
    logic [LEN_W-1:0]      lane_q;
    logic [LEN_W-1:0]      beat_q;
    logic                  last_beat;
    logic                  accept;
    logic [BYTE_W-1:0]     wbyte;
    logic [4*BYTE_W-1:0]   pack;

`ifdef MEM_REQ_BURST_EN
    logic [LEN_W-1:0]      beat_d;
    logic [LEN_W-1:0]      len_q;
    logic [4*BYTE_W-1:0]   wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
        end else begin
            beat_q <= beat_d;
            if (accept) begin
                len_q   <= req_len;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (accept) begin
            beat_d = '0;
        end else if (state_q == READ || state_q == WRITE) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    assign last_beat = (beat_q == len_q);
    assign wbyte     = wdata_q[beat_q*BYTE_W +: BYTE_W];
`else
    logic [BYTE_W-1:0]     wdata_q;
    logic                  unused_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q <= '0;
        end else if (accept) begin
            wdata_q <= req_wdata[BYTE_W-1:0];
        end
    end

    assign beat_q     = '0;
    assign last_beat  = 1'b1;
    assign wbyte      = wdata_q;
    assign unused_req = ^{req_len, req_wdata[4*BYTE_W-1:BYTE_W]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            bv_q    <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            bv_q    <= bv_d;
            lane_q  <= beat_q;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
            end
        end
    end

    // Read data returns a cycle late, so the beat tag is delayed to match.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bv_d           = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_write ? WRITE : READ;
                end
            end
            READ: begin
                mem_read    = 1'b1;
                mem_address = addr_q + ADDR_W'(beat_q);
                bv_d        = 1'b1;
                if (last_beat) begin
                    state_d = DRAIN;
                end
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = addr_q + ADDR_W'(beat_q);
                mem_write_data = wbyte;
                if (last_beat) begin
                    state_d = RESP;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = write_q ? '0 : pack;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_rsp_packer #(
        .BYTE_W (BYTE_W),
        .LEN_W  (LEN_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (accept),
        .beat_valid_i (bv_q),
        .lane_i       (lane_q),
        .byte_i       (mem_out),
        .data_o       (pack)
    );

endmodule

// File: tb/tb_mem_burst_requester.sv
// Directed bench for mem_burst_requester with a registered 32 x 8 memory model.
// Expectations follow the MEM_REQ_BURST_EN setting of the build.
module tb_mem_burst_requester;

`ifdef MEM_REQ_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [1:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_out = '0;

    logic [7:0]  mem_q [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;

    int n_checks = 0;
    int n_fail = 0;

    int rd_mask, wr_mask, rsp_cnt, rsp_cyc, rsp_cyc2, rdy_cyc;
    int both_cnt = 0;
    int quiet_bad = 0;
    logic [31:0] rsp_d, rsp_d2;
    logic [4:0]  addr_log [16];
    logic [7:0]  wd_log [16];

    always #5 clk = ~clk;

    mem_burst_requester dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_out        (mem_out)
    );

    always_ff @(posedge clk) begin
        if (pre_en) begin
            mem_q[pre_addr] <= pre_data;
        end else if (mem_write) begin
            mem_q[mem_address] <= mem_write_data;
        end
        if (mem_read) begin
            mem_out <= mem_q[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic clear_log();
        rd_mask  = 0;
        wr_mask  = 0;
        rsp_cnt  = 0;
        rsp_cyc  = -1;
        rsp_cyc2 = -1;
        rdy_cyc  = -1;
        rsp_d    = '0;
        rsp_d2   = '0;
    endtask

    task automatic sample(input int c);
        if (mem_read) rd_mask |= (1 << c);
        if (mem_write) wr_mask |= (1 << c);
        if (mem_read && mem_write) both_cnt++;
        if (!mem_read && !mem_write &&
            (mem_address != 0 || mem_write_data != 0)) quiet_bad++;
        if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
                rsp_cyc = c;
                rsp_d   = rsp_data;
            end else begin
                rsp_cyc2 = c;
                rsp_d2   = rsp_data;
            end
        end
        if (c > 0 && req_ready && rdy_cyc < 0) rdy_cyc = c;
        addr_log[c] = mem_address;
        wd_log[c]   = mem_write_data;
    endtask

    task automatic do_req(input logic wr, input logic [4:0] a,
                          input logic [1:0] l, input logic [31:0] wd);
        clear_log();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
        req_wdata = wd;
        #1;
        check("ready_c0", {31'b0, req_ready}, 32'd1);
        sample(0);
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_write = ~wr;
            req_addr  = ~a;
            req_len   = ~l;
            req_wdata = ~wd;
            #1;
            sample(c);
        end
    endtask

    task automatic check_req(input string tag, input logic wr,
                             input logic [4:0] a, input int len,
                             input logic [31:0] wd, input logic [31:0] exp_d);
        int L;
        int mask;
        L    = BURST ? len + 1 : 1;
        mask = ((1 << L) - 1) << 1;
        check({tag, "_rdmask"}, rd_mask, wr ? 0 : mask);
        check({tag, "_wrmask"}, wr_mask, wr ? mask : 0);
        check({tag, "_rspcnt"}, rsp_cnt, 1);
        check({tag, "_rspcyc"}, rsp_cyc, wr ? L + 1 : L + 2);
        check({tag, "_rdycyc"}, rdy_cyc, wr ? L + 2 : L + 3);
        check({tag, "_rspdat"}, rsp_d, exp_d);
        for (int k = 0; k < L; k++) begin
            check({tag, "_addr"}, {27'b0, addr_log[1+k]}, {27'b0, a + 5'(k)});
            if (wr) check({tag, "_wdat"}, {24'b0, wd_log[1+k]},
                          {24'b0, wd[8*k +: 8]});
        end
    endtask

    initial begin
        int rc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rspv", {31'b0, rsp_valid}, 32'd0);
        check("rst_rspd", rsp_data, 32'd0);
        check("rst_cmd", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_addr", {19'b0, mem_address, mem_write_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(5'd5, 8'hA7);
        preload(5'd31, 8'hCC);
        preload(5'd12, 8'h5C);
        preload(5'd13, 8'h6D);
        preload(5'd14, 8'h7E);
        preload(5'd15, 8'h8F);

        do_req(1'b0, 5'd5, 2'd0, 32'h0);
        check_req("ld5", 1'b0, 5'd5, 0, 32'h0, 32'h000000A7);

        do_req(1'b1, 5'd30, 2'd3, 32'h44332211);
        check_req("st30", 1'b1, 5'd30, 3, 32'h44332211, 32'h0);
        check("st30_m30", {24'b0, mem_q[30]}, 32'h11);
        if (BURST != 0) begin
            check("st30_m31", {24'b0, mem_q[31]}, 32'h22);
            check("st30_m0", {24'b0, mem_q[0]}, 32'h33);
            check("st30_m1", {24'b0, mem_q[1]}, 32'h44);
        end else begin
            check("st30_m31", {24'b0, mem_q[31]}, 32'hCC);
        end

        do_req(1'b0, 5'd30, 2'd3, 32'h0);
        check_req("ld30", 1'b0, 5'd30, 3, 32'h0,
                  BURST ? 32'h44332211 : 32'h00000011);

        do_req(1'b0, 5'd12, 2'd3, 32'h0);
        check_req("ld12", 1'b0, 5'd12, 3, 32'h0,
                  BURST ? 32'h8F7E6D5C : 32'h0000005C);

        clear_log();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd5;
        req_len   = 2'd0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 8) req_valid = 1'b0;
            #1;
            sample(c);
        end
        check("b2b_rdmask", rd_mask, 32'h22);
        check("b2b_rspcnt", rsp_cnt, 2);
        check("b2b_rspcyc1", rsp_cyc, 3);
        check("b2b_rspcyc2", rsp_cyc2, 7);
        check("b2b_rdycyc", rdy_cyc, 4);
        check("b2b_rspd1", rsp_d, 32'h000000A7);
        check("b2b_rspd2", rsp_d2, 32'h000000A7);

        preload(5'd1, 8'hEE);
        rc = BURST ? 3 : 1;
        clear_log();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd30;
        req_len   = 2'd3;
        req_wdata = 32'h99887766;
        #1;
        sample(0);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c == rc) rst = 1'b1;
            if (c == rc + 1) rst = 1'b0;
            #1;
            if (c == rc) check("rstmid_wr", {31'b0, mem_write}, 32'd1);
            if (c == rc + 1) begin
                check("rstmid_ready", {31'b0, req_ready}, 32'd1);
                check("rstmid_cmd", {30'b0, mem_read, mem_write}, 32'd0);
                check("rstmid_addr", {19'b0, mem_address, mem_write_data}, 32'd0);
                check("rstmid_rsp", {31'b0, rsp_valid}, 32'd0);
                check("rstmid_rspd", rsp_data, 32'd0);
            end
            sample(c);
        end
        check("rstmid_rspcnt", rsp_cnt, 0);
        check("rstmid_wrmask", wr_mask, ((1 << rc) - 1) << 1);
        check("rstmid_m1", {24'b0, mem_q[1]}, 32'hEE);
        if (BURST != 0) check("rstmid_m31", {24'b0, mem_q[31]}, 32'h77);

        do_req(1'b0, 5'd5, 2'd0, 32'h0);
        check_req("ld5b", 1'b0, 5'd5, 0, 32'h0, 32'h000000A7);

        check("cmd_overlap", both_cnt, 0);
        check("quiet_bus", quiet_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
